// File: rtl/rgb_pkg.sv
// Shared definitions for the WS2812b word/serial conversion paths (capture and transmit).
// Timing constants assume the 96 MHz PLL clock.
package rgb_pkg;

  localparam int BNUM_VALID          = 31;
  localparam int BNUM_STREAM_RESET   = 30;
  localparam int BNUM_FIRST_DATA_BIT = 23;
  localparam int BNUM_LAST_DATA_BIT  = 0;

  localparam int T0H_CLKS  = 38;    // 0.40 us
  localparam int T1H_CLKS  = 77;    // 0.80 us
  localparam int TBIT_CLKS = 120;   // 1.25 us
  localparam int TRST_CLKS = 5280;  // 55 us

  localparam int CNT_W     = 13;
  localparam int BIT_CNT_W = 7;
  localparam int IDX_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_BIT_HIGH,
    ST_BIT_LOW,
    ST_RST_LOW
  } state_t;

  function automatic logic [BIT_CNT_W-1:0] high_clks(input logic bit_val);
    return bit_val ? BIT_CNT_W'(T1H_CLKS) : BIT_CNT_W'(T0H_CLKS);
  endfunction

endpackage

// File: rtl/rgb_sout_bitgen.sv
// Single-bit WS2812b waveform generator. The cycle with start=1 is the first high clock;
// bit_done marks the last low clock of the TBIT_CLKS period.
module rgb_sout_bitgen
  import rgb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic sout,
  output logic bit_done
);

  logic [BIT_CNT_W-1:0] cnt;
  logic                 active;
  logic                 one_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      one_q  <= 1'b0;
    end else if (start) begin
      cnt    <= BIT_CNT_W'(1);
      active <= 1'b1;
      one_q  <= bit_val;
    end else if (active) begin
      if (bit_done) active <= 1'b0;
      else          cnt    <= cnt + BIT_CNT_W'(1);
    end
  end

  assign bit_done = active && (cnt == BIT_CNT_W'(TBIT_CLKS - 1));
  // The start cycle is high on its own so a bit can begin in the very cycle its data arrives.
  assign sout     = start || (active && (cnt < high_clks(one_q)));

endmodule

// File: rtl/rgb_wrd2sout.sv
// Pops Status/G/R/B words from a FIFO and serialises them as a WS2812b stream,
// prefetching the next word so consecutive bits stay exactly one bit period apart.
module rgb_wrd2sout
  import rgb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_word,
  input  logic        in_rd_fifo_empty,
  output logic        out_rd_strobe,
  output logic        out_sout,
  output logic        out_busy,
  output logic        out_underrun
);

  state_t                           state, state_nxt;
  logic [BNUM_FIRST_DATA_BIT:0]     shreg;
  logic [IDX_W-1:0]                 bit_idx;
  logic [CNT_W-1:0]                 rst_cnt;
  logic                             from_low;
  logic                             underrun_q;

  logic word_valid, word_rst, is_data_word, last_bit;
  logic bg_start, bg_bit, bg_sout, bg_done;
  logic rd_strobe, load_data, load_rst, shift_en, set_underrun;
  logic unused_spare;

  assign word_valid   = in_word[BNUM_VALID];
  assign word_rst     = in_word[BNUM_STREAM_RESET];
  assign is_data_word = word_valid && !word_rst;
  assign last_bit     = (bit_idx == IDX_W'(BNUM_LAST_DATA_BIT));
  assign unused_spare = ^in_word[BNUM_STREAM_RESET-1:BNUM_FIRST_DATA_BIT+1];

  // A bit starts either in LOAD (data straight from the FIFO) or on re-entry to BIT_HIGH.
  assign bg_start = ((state == ST_LOAD) && is_data_word) || ((state == ST_BIT_HIGH) && from_low);
  assign bg_bit   = (state == ST_LOAD) ? in_word[BNUM_FIRST_DATA_BIT] : shreg[BNUM_FIRST_DATA_BIT];

  rgb_sout_bitgen u_bitgen (
    .clk      (clk),
    .rst      (rst),
    .start    (bg_start),
    .bit_val  (bg_bit),
    .sout     (bg_sout),
    .bit_done (bg_done)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt    = state;
    rd_strobe    = 1'b0;
    load_data    = 1'b0;
    load_rst     = 1'b0;
    shift_en     = 1'b0;
    set_underrun = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!in_rd_fifo_empty) begin
          rd_strobe = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (!word_valid) begin
          state_nxt = ST_IDLE;
        end else if (word_rst) begin
          load_rst  = 1'b1;
          state_nxt = ST_RST_LOW;
        end else begin
          load_data = 1'b1;
          state_nxt = ST_BIT_HIGH;
        end
      end
      ST_BIT_HIGH: begin
        if (!bg_sout) state_nxt = ST_BIT_LOW;
      end
      ST_BIT_LOW: begin
        if (bg_done) begin
          if (!last_bit) begin
            shift_en  = 1'b1;
            state_nxt = ST_BIT_HIGH;
          end else if (!in_rd_fifo_empty) begin
            // Pipelined read: the word lands in LOAD, which is the next bit's first high clock.
            rd_strobe = 1'b1;
            state_nxt = ST_LOAD;
          end else begin
            set_underrun = 1'b1;
            state_nxt    = ST_IDLE;
          end
        end
      end
      ST_RST_LOW: begin
        if (rst_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      rst_cnt    <= '0;
      from_low   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      from_low <= (state == ST_BIT_LOW);
      if (load_data) begin
        shreg   <= in_word[BNUM_FIRST_DATA_BIT:BNUM_LAST_DATA_BIT];
        bit_idx <= IDX_W'(BNUM_FIRST_DATA_BIT);
      end else if (shift_en) begin
        shreg   <= {shreg[BNUM_FIRST_DATA_BIT-1:0], 1'b0};
        bit_idx <= bit_idx - IDX_W'(1);
      end
      if (load_rst)            rst_cnt <= CNT_W'(TRST_CLKS - 1);
      else if (rst_cnt != '0)  rst_cnt <= rst_cnt - CNT_W'(1);
      if (set_underrun) underrun_q <= 1'b1;
    end
  end

  // IDLE would otherwise request a read while reset is still held.
  assign out_rd_strobe = rd_strobe && !rst;
  assign out_sout      = bg_sout;
  assign out_busy      = (state != ST_IDLE);
  assign out_underrun  = underrun_q;

endmodule

// File: tb/tb_rgb_wrd2sout.sv
// Self-checking bench for rgb_wrd2sout: a FIFO model feeds words, the serial output is
// measured pulse by pulse and compared with expectations derived from the words.
module tb_rgb_wrd2sout;

  localparam int T0H  = 38;
  localparam int T1H  = 77;
  localparam int TBIT = 120;
  localparam int TRST = 5280;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_word;
  logic        in_rd_fifo_empty;
  logic        out_rd_strobe, out_sout, out_busy, out_underrun;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] words[$];
  int          rise_q[$];
  int          high_q[$];
  int          exp_high_q[$];
  int          exp_gap_q[$];
  int          exp_underrun, exp_strobes;
  int          cyc = 0;
  int          strobe_cnt, busy_cnt, busy_fall, cur_high, rd_empty_err;
  logic        prev_sout, prev_busy;

  rgb_wrd2sout dut (
    .clk              (clk),
    .rst              (rst),
    .in_word          (in_word),
    .in_rd_fifo_empty (in_rd_fifo_empty),
    .out_rd_strobe    (out_rd_strobe),
    .out_sout         (out_sout),
    .out_busy         (out_busy),
    .out_underrun     (out_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected pulse widths and rising-edge spacing, straight from the word format.
  function automatic void build_model();
    bit prev_data = 1'b0;
    bit is_data;
    exp_high_q.delete();
    exp_gap_q.delete();
    foreach (words[k]) begin
      is_data = words[k][31] && !words[k][30];
      if (is_data) begin
        for (int b = 23; b >= 0; b--) begin
          exp_high_q.push_back(words[k][b] ? T1H : T0H);
          exp_gap_q.push_back((b == 23 && !prev_data) ? -1 : TBIT);
        end
      end
      prev_data = is_data;
    end
    exp_underrun = prev_data ? 1 : 0;
    exp_strobes  = words.size();
  endfunction

  function automatic void clear_capture();
    rise_q.delete();
    high_q.delete();
    strobe_cnt   = 0;
    busy_cnt     = 0;
    busy_fall    = -1;
    cur_high     = 0;
    rd_empty_err = 0;
    prev_sout    = 1'b0;
    prev_busy    = 1'b0;
  endfunction

  // One clock: observe outputs mid-cycle, then update the FIFO model after the edge.
  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = out_rd_strobe;
    if (rd) strobe_cnt++;
    if (rd && in_rd_fifo_empty) rd_empty_err++;
    if (out_busy) busy_cnt++;
    if (prev_busy && !out_busy) busy_fall = cyc;
    if (out_sout && !prev_sout) begin
      rise_q.push_back(cyc);
      cur_high = 0;
    end
    if (out_sout) cur_high++;
    if (!out_sout && prev_sout) high_q.push_back(cur_high);
    prev_sout = out_sout;
    prev_busy = out_busy;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) in_word = fifo_q.pop_front();
    in_rd_fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic start_frame();
    clear_capture();
    build_model();
    fifo_q = words;
    in_rd_fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      tick();
      n++;
      if (!prev_busy && fifo_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check({tag, ".reached_idle"}, quiet >= 4, 1);
  endtask

  task automatic compare_stream(input string tag);
    int hi_bad = 0;
    int gap_bad = 0;
    for (int i = 0; i < high_q.size() && i < exp_high_q.size(); i++)
      if (high_q[i] != exp_high_q[i]) hi_bad++;
    for (int i = 1; i < rise_q.size() && i < exp_gap_q.size(); i++)
      if (exp_gap_q[i] >= 0 && (rise_q[i] - rise_q[i-1]) != exp_gap_q[i]) gap_bad++;
    check({tag, ".pulses"},         high_q.size(), exp_high_q.size());
    check({tag, ".high_bad"},       hi_bad, 0);
    check({tag, ".period_bad"},     gap_bad, 0);
    check({tag, ".underrun"},       out_underrun, exp_underrun);
    check({tag, ".strobes"},        strobe_cnt, exp_strobes);
    check({tag, ".rd_while_empty"}, rd_empty_err, 0);
  endtask

  task automatic do_reset();
    fifo_q.delete();
    in_rd_fifo_empty = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int tgt;
    logic [31:0] w;
    rst              = 1'b1;
    in_word          = '0;
    in_rd_fifo_empty = 1'b1;
    #1;
    check("reset.sout",     out_sout, 0);
    check("reset.strobe",   out_rd_strobe, 0);
    check("reset.busy",     out_busy, 0);
    check("reset.underrun", out_underrun, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word, then underrun.
    words = {32'h80F00FA5};
    start_frame();
    run_until_idle("single", 24 * TBIT + 200);
    compare_stream("single");

    // Asynchronous reset during clock 40 of a 1-bit high phase; underrun is still set from above.
    check("areset.underrun_before", out_underrun, 1);
    words = {32'h80800000, 32'h805A5A5A};
    start_frame();
    n = 0;
    while (rise_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    check("areset.rise_seen", rise_q.size() > 0, 1);
    tgt = (rise_q.size() > 0) ? rise_q[0] + 39 : cyc;
    n = 0;
    while (cyc < tgt && n < 200) begin
      tick();
      n++;
    end
    #2;
    check("areset.high_before", out_sout, 1);
    rst = 1'b1;
    #1;
    check("areset.sout",     out_sout, 0);
    check("areset.strobe",   out_rd_strobe, 0);
    check("areset.busy",     out_busy, 0);
    check("areset.underrun", out_underrun, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("areset.first_read", out_rd_strobe, 1);
    words = {32'h805A5A5A};
    build_model();
    clear_capture();
    run_until_idle("restart", 24 * TBIT + 200);
    compare_stream("restart");

    // Back-to-back data words, then a stream reset.
    do_reset();
    words = {32'h80000000, 32'h80FFFFFF, 32'hC0000000};
    start_frame();
    run_until_idle("b2b", 48 * TBIT + TRST + 300);
    compare_stream("b2b");
    check("b2b.boundary_gap", (rise_q.size() >= 25) ? rise_q[24] - rise_q[23] : -1, TBIT);
    // Slot after the last bit: one LOAD clock, then the full stream reset low time.
    check("b2b.tail_to_idle", (rise_q.size() > 0) ? busy_fall - rise_q[$] : -1, TBIT + 1 + TRST);

    // Invalid word is discarded: FETCH and LOAD only.
    do_reset();
    words = {32'h00123456};
    start_frame();
    run_until_idle("invalid", 50);
    compare_stream("invalid");
    check("invalid.busy_clks", busy_cnt, 2);

    do_reset();
    words = {32'h40ABCDEF};
    start_frame();
    run_until_idle("rst_invalid", 50);
    compare_stream("rst_invalid");
    check("rst_invalid.busy_clks", busy_cnt, 2);

    do_reset();
    words = {32'hC0ABCDEF};
    start_frame();
    run_until_idle("rst_valid", TRST + 100);
    compare_stream("rst_valid");
    check("rst_valid.busy_clks", busy_cnt, TRST + 2);

    // Random frames: 1-3 data words, optionally closed by a stream reset or an invalid word.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      words.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        w = $urandom();
        w[31] = 1'b1;
        w[30] = 1'b0;
        words.push_back(w);
      end
      w = $urandom();
      case ($urandom_range(0, 2))
        1: begin w[31] = 1'b1; w[30] = 1'b1; words.push_back(w); end
        2: begin w[31] = 1'b0; words.push_back(w); end
        default: ;
      endcase
      start_frame();
      run_until_idle($sformatf("rand%0d", it), words.size() * 24 * TBIT + TRST + 500);
      compare_stream($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_wrd2sout.md
Name: rgb_wrd2sout

Overview:
- Transmit-side counterpart of the serial-bit-to-word capture path.
- Pops 32-bit Status/Green/Red/Blue words from a FIFO and regenerates a WS2812b-compatible serial stream on one output pin, including the 50 us stream reset (latch) interval.
- Runs on the 96 MHz PLL clock and feeds the LED chain downstream of the RGB/RGBW conversion logic.

Parameters:
- T0H_CLKS, 38: high time of a "0" bit, in clocks (0.40 us).
- T1H_CLKS, 77: high time of a "1" bit, in clocks (0.80 us).
- TBIT_CLKS, 120: total bit period, in clocks (1.25 us). Low time is TBIT_CLKS minus the high time.
- TRST_CLKS, 5280: stream reset low time, in clocks (55 us, above the 50 us minimum).

Ports:
- clk  in  1  96 MHz clock.
- rst  in  1  Reset, asynchronous, active-high.
- in_word  in  32  FIFO read data. Bit 31 = valid, bit 30 = stream_reset, bits 29..24 spare, bits 23..0 = G[23:16] R[15:8] B[7:0].
- in_rd_fifo_empty  in  1  FIFO is empty.
- out_rd_strobe  out  1  FIFO read enable, one clock wide. in_word is valid on the following clock.
- out_sout  out  1  Serial WS2812b output. Idle level is low.
- out_busy  out  1  High whenever the state is not IDLE.
- out_underrun  out  1  Sticky. FIFO was empty when the next word of a frame was needed.

Behaviour:
- Reset (asynchronous assert):
  - All outputs are 0 and the state is IDLE.
  - A reset during a bit or stream reset aborts it immediately; out_sout goes low at once.
  - Release is synchronous to clk; the first FIFO read is issued on the first clock after release if the FIFO is not empty.
- States: IDLE, FETCH, LOAD, BIT_HIGH, BIT_LOW, RST_LOW.
- IDLE: out_sout=0. If in_rd_fifo_empty=0, assert out_rd_strobe and go to FETCH.
- FETCH: out_rd_strobe=0. Go to LOAD (read latency of 1 clock).
- LOAD: capture in_word.
  - valid=0: discard the word, go to IDLE.
  - stream_reset=1: load the counter with TRST_CLKS-1 and go to RST_LOW. Data bits in the word are ignored (partial word).
  - Otherwise: shift register = bits 23..0, bit index = 23, drive out_sout=1 in the same cycle, go to BIT_HIGH.
- BIT_HIGH: out_sout=1 for exactly T0H_CLKS or T1H_CLKS clocks, selected by the current MSB. Then go to BIT_LOW.
- BIT_LOW: out_sout=0 until the high and low times together total exactly TBIT_CLKS.
  - If bits remain: shift left, decrement the index, go to BIT_HIGH.
  - After bit 0, if the FIFO is not empty: issue the next read in the same cycle as the last low clock, so the next word starts with no gap.
  - After bit 0, if the FIFO is empty: set out_underrun=1 and go to IDLE.
- RST_LOW: out_sout=0 for exactly TRST_CLKS clocks, then go to IDLE.
  - An empty FIFO here is not an underrun; the frame has ended.
- Back-to-back words: the pipelined read is required because FETCH and LOAD may not be inserted inside the bit period. Consecutive bits are spaced exactly TBIT_CLKS apart, including across word boundaries.
- Counter: 13 bits, down-counting, saturates at 0.
- Bit order: MSB first (G7 first, B0 last).
- out_rd_strobe is never asserted while in_rd_fifo_empty=1.
- out_underrun is cleared only by rst.

Decomposition:
- Shared package rgb_pkg holds:
  - Word bit indices: BNUM_VALID=31, BNUM_STREAM_RESET=30, BNUM_FIRST_DATA_BIT=23, BNUM_LAST_DATA_BIT=0.
  - Timing constants for 96 MHz.
  - The state encoding.
- The capture block uses the same package constants.
- One sub-module is natural: rgb_sout_bitgen. Inputs: start, bit value. Outputs: out_sout and bit_done. It owns the T0H/T1H/TBIT counter, and the top-level FSM owns fetch and word sequencing.

Test Plan:
- Single word 0x80_F0_0F_A5, then empty FIFO:
  - Exactly 24 pulses.
  - High times match the pattern 11110000 00001111 10100101 at 77 and 38 clocks.
  - Every bit period is 120 clocks.
  - out_underrun=1 afterwards.
- FIFO holding 0x80_000000, 0x80_FFFFFF, 0xC0_000000:
  - 48 bits with no gap at the word boundary (bit 23 to bit 24 rising edges exactly 120 clocks apart).
  - Then 5280 clocks low, then IDLE with out_busy=0.
  - out_underrun stays 0.
- Word 0x00_123456 (valid=0):
  - No pulses on out_sout.
  - One out_rd_strobe.
  - Returns to IDLE within 3 clocks.
- Word 0x40_ABCDEF (stream_reset set, valid=0) versus 0xC0_ABCDEF:
  - The first is discarded with no low interval.
  - The second gives 5280 low clocks and no data pulses.
- Assert rst asynchronously in the middle of a 1-bit high phase (clock 40):
  - out_sout falls before the next clk edge.
  - All outputs are 0, including the previously set out_underrun.
  - Transmission restarts from the next FIFO word after release.
